// File: rtl/axi_pkg.sv
// Shared AXI4 read constants and types for the burst reader slice.
package axi_pkg;
  localparam int AXI_ADDR_W     = 64;
  localparam int AXI_DATA_W     = 512;
  localparam int AXI_ID_W       = 16;
  localparam int WORDS_PER_LINE = 16;
  localparam logic [2:0] AXI_SIZE_64B = 3'd6;
  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} rd_state_e;

  // Word idx of a 64-byte line, lowest address in bits [31:0].
  function automatic logic [31:0] line_word(input logic [AXI_DATA_W-1:0] line,
                                            input logic [3:0] idx);
    return line[idx*32 +: 32];
  endfunction
endpackage

// File: rtl/axi_burst_reader_if.sv
// AXI4 AR/R channel bundle between the burst reader and the memory slave.
interface axi_burst_reader_if;
  import axi_pkg::*;
  logic [AXI_ID_W-1:0]   arid_m;
  logic [AXI_ADDR_W-1:0] araddr_m;
  logic [7:0]            arlen_m;
  logic [2:0]            arsize_m;
  logic                  arvalid_m;
  logic                  arready_m;
  logic [AXI_ID_W-1:0]   rid_m;
  logic [AXI_DATA_W-1:0] rdata_m;
  logic [1:0]            rresp_m;
  logic                  rlast_m;
  logic                  rvalid_m;
  logic                  rready_m;

  modport master (output arid_m, araddr_m, arlen_m, arsize_m, arvalid_m, rready_m,
                  input  arready_m, rid_m, rdata_m, rresp_m, rlast_m, rvalid_m);
  modport slave  (input  arid_m, araddr_m, arlen_m, arsize_m, arvalid_m, rready_m,
                  output arready_m, rid_m, rdata_m, rresp_m, rlast_m, rvalid_m);
endinterface

// File: rtl/line_fifo.sv
// Synchronous line FIFO; head entry is readable combinationally.
module line_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 512
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           wdata,
  input  logic                   pop,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end

  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/axi_burst_reader.sv
// AXI4 read master: fetches a word array as 64B-line bursts and streams it
// out one 32-bit word per accepted beat, lowest address first.
module axi_burst_reader
  import axi_pkg::*;
#(
  parameter int ID         = 0,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AXI_ADDR_W-1:0] base_addr,
  input  logic [31:0]           count,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  axi_burst_reader_if.master    bus,
  output logic [31:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int LW = 29;

  rd_state_e             state, state_nx;
  logic [AXI_ADDR_W-7:0] line_addr;
  logic [LW-1:0]         lines_rem, drain_rem, beats, page_room, job_lines;
  logic [3:0]            tail_m1, wptr;
  logic [CW-1:0]         outstanding, free_cr, fifo_cnt;
  logic [AXI_DATA_W-1:0] head;
  logic                  ar_fire, r_fire, out_fire, pop, line_done, job_last, done_nx;
  logic                  unused_ok;

  assign unused_ok = ^{bus.rlast_m, base_addr[5:0]};
  assign job_lines = LW'((33'(count) + 33'd15) >> 4);

  // Burst never exceeds MAX_BURST, the remaining lines, or the 4 KB page.
  always_comb begin
    page_room = LW'(64) - LW'(line_addr[5:0]);
    beats     = lines_rem;
    if (beats > LW'(MAX_BURST)) beats = LW'(MAX_BURST);
    if (beats > page_room)      beats = page_room;
  end

  assign free_cr       = CW'(FIFO_DEPTH) - outstanding;
  assign bus.arid_m    = AXI_ID_W'(ID);
  assign bus.arsize_m  = AXI_SIZE_64B;
  assign bus.araddr_m  = {line_addr, 6'b0};
  assign bus.arlen_m   = (state == S_ISSUE) ? 8'(beats - 1'b1) : 8'd0;
  assign bus.arvalid_m = (state == S_ISSUE) && (LW'(free_cr) >= beats);
  assign bus.rready_m  = 1'b1;
  assign ar_fire       = bus.arvalid_m && bus.arready_m;
  assign r_fire        = bus.rvalid_m && (bus.rid_m == AXI_ID_W'(ID)) && (state != S_IDLE);

  line_fifo #(.DEPTH(FIFO_DEPTH), .W(AXI_DATA_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r_fire),
    .wdata (bus.rdata_m),
    .pop   (pop),
    .rdata (head),
    .count (fifo_cnt)
  );

  // The final line of the job stops short at word tail-1.
  assign job_last  = (drain_rem == LW'(1));
  assign line_done = job_last ? (wptr == tail_m1) : (wptr == 4'(WORDS_PER_LINE - 1));
  assign out_valid = (state != S_IDLE) && (fifo_cnt != '0);
  assign out_data  = line_word(head, wptr);
  assign out_last  = out_valid && job_last && (wptr == tail_m1);
  assign out_fire  = out_valid && out_ready;
  assign pop       = out_fire && line_done;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        if (count == '0) done_nx = 1'b1;
        else             state_nx = S_ISSUE;
      end
      S_ISSUE: if (ar_fire && (lines_rem == beats)) state_nx = S_DRAIN;
      S_DRAIN: ;
      default: state_nx = S_IDLE;
    endcase
    if ((state != S_IDLE) && out_fire && out_last) begin
      state_nx = S_IDLE;
      done_nx  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state       <= S_IDLE;
      line_addr   <= '0;
      lines_rem   <= '0;
      drain_rem   <= '0;
      tail_m1     <= '0;
      wptr        <= '0;
      outstanding <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= done_nx;
      if (state == S_IDLE) begin
        if (start) begin
          line_addr <= base_addr[AXI_ADDR_W-1:6];
          lines_rem <= job_lines;
          drain_rem <= job_lines;
          tail_m1   <= count[3:0] - 4'd1;
          wptr      <= '0;
          err       <= 1'b0;
        end
      end else begin
        if (ar_fire) begin
          line_addr <= line_addr + (AXI_ADDR_W-6)'(beats);
          lines_rem <= lines_rem - beats;
        end
        if (r_fire && (bus.rresp_m != RESP_OKAY)) err <= 1'b1;
        if (out_fire) begin
          wptr <= line_done ? 4'd0 : wptr + 4'd1;
          if (line_done) drain_rem <= drain_rem - LW'(1);
        end
      end
      // Reservation and release may land in the same cycle.
      outstanding <= outstanding + (ar_fire ? CW'(beats) : CW'(0)) - CW'(pop);
    end
endmodule

// File: tb/tb_axi_burst_reader.sv
// Directed bench for axi_burst_reader with a behavioural in-order AXI slave.
`timescale 1ns/1ps
module tb_axi_burst_reader;
  import axi_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] base_addr = '0;
  logic [31:0] count = '0;
  logic        busy, done, err;
  logic [31:0] out_data;
  logic        out_valid, out_last;
  logic        out_ready = 1'b0;

  axi_burst_reader_if bus();

  axi_burst_reader #(.ID(0), .MAX_BURST(16), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .busy(busy), .done(done), .err(err), .bus(bus),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] base; int cnt; bit rnd; int n_ar;
    int len0; logic [63:0] addr0; int len1; logic [63:0] addr1; int len_last;
    logic [31:0] word0;
  } vec_t;
  typedef struct { logic [63:0] addr; bit last; } beat_t;

  vec_t vt[5];
  int vectors = 0, miscompares = 0;

  beat_t       r_q[$];
  int          ar_len[$];
  logic [63:0] ar_addr[$];
  logic [31:0] words[$];
  bit          lasts[$];
  int cyc = 0, issued_lines, lines_total, beat_idx, err_beat = -1;
  int start_cyc, first_arv_cyc, first_rv_cyc, first_ov_cyc, last_acc_cyc, done_cyc;
  int done_cnt, stall_cyc, ovf_err, stab_err, arv_seen, ov_seen;
  bit err_at_done, busy_at_done, rnd = 1'b0, prev_stall = 1'b0;
  logic [63:0] prev_addr;
  logic [7:0]  prev_len;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] mkline(input logic [63:0] a);
    logic [511:0] l;
    logic [31:0]  w0;
    w0 = 32'(a >> 2);
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = w0 + 32'(i);
    return l;
  endfunction

  task automatic clear_mon();
    ar_len.delete(); ar_addr.delete(); words.delete(); lasts.delete();
    issued_lines = 0; beat_idx = 0; done_cnt = 0; stall_cyc = 0; ovf_err = 0;
    stab_err = 0; arv_seen = 0; ov_seen = 0; start_cyc = -1; first_arv_cyc = -1;
    first_rv_cyc = -1; first_ov_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
    err_at_done = 1'b0; busy_at_done = 1'b1;
  endtask

  // Slave + stream sink: drive on the falling edge, observe 1 ns later.
  always @(negedge clk) begin
    cyc++;
    bus.arready_m = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    if (r_q.size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
      bus.rvalid_m = 1'b1;
      bus.rdata_m  = mkline(r_q[0].addr);
      bus.rlast_m  = r_q[0].last;
      bus.rresp_m  = (beat_idx == err_beat) ? RESP_SLVERR : RESP_OKAY;
    end else begin
      bus.rvalid_m = 1'b0;
      bus.rresp_m  = RESP_OKAY;
    end
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (bus.arvalid_m) begin
      arv_seen++;
      if (first_arv_cyc < 0) first_arv_cyc = cyc;
    end
    if (out_valid) ov_seen++;
    if (prev_stall && (!bus.arvalid_m || bus.araddr_m != prev_addr || bus.arlen_m != prev_len))
      stab_err++;
    prev_stall = bus.arvalid_m && !bus.arready_m;
    prev_addr  = bus.araddr_m;
    prev_len   = bus.arlen_m;
    if (start && !busy && rst) start_cyc = cyc;
    if (bus.arvalid_m && bus.arready_m) begin
      ar_len.push_back(int'(bus.arlen_m));
      ar_addr.push_back(bus.araddr_m);
      for (int b = 0; b <= int'(bus.arlen_m); b++)
        r_q.push_back('{addr: bus.araddr_m + 64'(64 * b), last: (b == int'(bus.arlen_m))});
      issued_lines += int'(bus.arlen_m) + 1;
      if (issued_lines - words.size() / 16 > 16) ovf_err++;
    end else if (busy && !bus.arvalid_m && issued_lines < lines_total) stall_cyc++;
    if (bus.rvalid_m && bus.rready_m) begin
      if (first_rv_cyc < 0) first_rv_cyc = cyc;
      void'(r_q.pop_front());
      beat_idx++;
    end
    if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
    if (out_valid && out_ready) begin
      words.push_back(out_data);
      lasts.push_back(out_last);
      last_acc_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      err_at_done  = err;
      busy_at_done = busy;
    end
  end

  task automatic do_start(logic [63:0] b, int c, bit r);
    @(negedge clk); #2;
    clear_mon();
    rnd = r;
    lines_total = (c + 15) / 16;
    @(negedge clk);
    base_addr = b; count = 32'(c); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(string name);
    int t = 0;
    while (done_cnt == 0 && t < 20000) begin @(negedge clk); t++; end
    @(negedge clk); @(negedge clk); #2;
    chk($sformatf("%s_done_once", name), done_cnt, 1);
  endtask

  task automatic check_words(string name, int c, logic [31:0] w0);
    int bad = 0, nlast = 0, lpos = -1;
    for (int k = 0; k < words.size(); k++) begin
      if (words[k] !== w0 + 32'(k)) bad++;
      if (lasts[k]) begin nlast++; if (lpos < 0) lpos = k; end
    end
    chk($sformatf("%s_nwords", name), words.size(), c);
    chk($sformatf("%s_data_errs", name), bad, 0);
    chk($sformatf("%s_nlast", name), nlast, 1);
    chk($sformatf("%s_last_idx", name), lpos, c - 1);
    chk($sformatf("%s_done_lat", name), done_cyc, last_acc_cyc + 1);
    chk($sformatf("%s_busy_at_done", name), busy_at_done, 0);
  endtask

  task automatic run_vec(string name, vec_t v);
    do_start(v.base, v.cnt, v.rnd);
    wait_done(name);
    check_words(name, v.cnt, v.word0);
    chk($sformatf("%s_nar", name), ar_len.size(), v.n_ar);
    chk($sformatf("%s_len0", name), ar_len.size() > 0 ? ar_len[0] : -1, v.len0);
    chk($sformatf("%s_addr0", name), ar_addr.size() > 0 ? ar_addr[0] : '1, v.addr0);
    if (v.n_ar > 1) begin
      chk($sformatf("%s_len1", name), ar_len.size() > 1 ? ar_len[1] : -1, v.len1);
      chk($sformatf("%s_addr1", name), ar_addr.size() > 1 ? ar_addr[1] : '1, v.addr1);
    end
    chk($sformatf("%s_len_last", name), ar_len.size() > 0 ? ar_len[$] : -1, v.len_last);
    chk($sformatf("%s_start_to_arv", name), first_arv_cyc, start_cyc + 1);
    chk($sformatf("%s_r_to_word", name), first_ov_cyc, first_rv_cyc + 1);
    chk($sformatf("%s_err", name), err_at_done, 0);
    chk($sformatf("%s_credit_ovf", name), ovf_err, 0);
    chk($sformatf("%s_ar_stable", name), stab_err, 0);
    if (v.rnd) chk($sformatf("%s_ar_stalled", name), stall_cyc > 0, 1);
  endtask

  task automatic chk_reset_vals(string name);
    chk({name, "_arvalid"}, bus.arvalid_m, 0);
    chk({name, "_rready"}, bus.rready_m, 1);
    chk({name, "_out_valid"}, out_valid, 0);
    chk({name, "_out_last"}, out_last, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_err"}, err, 0);
    chk({name, "_arid"}, bus.arid_m, 0);
    chk({name, "_arsize"}, bus.arsize_m, 6);
    chk({name, "_araddr"}, bus.araddr_m, 0);
    chk({name, "_arlen"}, bus.arlen_m, 0);
  endtask

  initial begin
    int t;
    bus.arready_m = 1'b0; bus.rvalid_m = 1'b0; bus.rid_m = '0;
    bus.rdata_m = '0; bus.rresp_m = RESP_OKAY; bus.rlast_m = 1'b0;
    clear_mon();
    lines_total = 0;
    vt[0] = '{64'h1000, 16,   1'b0, 1, 0,  64'h1000, 0,  64'h0,    0,  32'h400};
    vt[1] = '{64'h0,    300,  1'b0, 2, 15, 64'h0,    2,  64'h400,  2,  32'h0};
    vt[2] = '{64'hFC0,  64,   1'b0, 2, 0,  64'hFC0,  2,  64'h1000, 2,  32'h3F0};
    vt[3] = '{64'h5A,   5,    1'b0, 1, 0,  64'h40,   0,  64'h0,    0,  32'h10};
    vt[4] = '{64'h2000, 2000, 1'b1, 8, 15, 64'h2000, 15, 64'h2400, 12, 32'h800};

    #1 rst = 1'b0;
    #1 chk_reset_vals("rst");
    #20 rst = 1'b1;

    for (int i = 0; i < 5; i++) run_vec($sformatf("v%0d", i), vt[i]);

    // Zero-length job: done next cycle, no AR.
    do_start(64'h3000, 0, 1'b0);
    wait_done("cnt0");
    chk("cnt0_arvalid_seen", arv_seen, 0);
    chk("cnt0_done_lat", done_cyc, start_cyc + 1);
    chk("cnt0_busy_at_done", busy_at_done, 0);

    // SLVERR on beat 1: err sticky through done, data still delivered.
    err_beat = 1;
    do_start(64'h0, 32, 1'b0);
    wait_done("slverr");
    check_words("slverr", 32, 32'h0);
    chk("slverr_err_at_done", err_at_done, 1);
    repeat (3) @(negedge clk);
    #2 chk("slverr_err_sticky", err, 1);

    // Long job with an early error, then asynchronous reset mid-stream.
    err_beat = 3;
    do_start(64'h2000, 2000, 1'b1);
    #2 chk("rstjob_err_cleared", err, 0);
    repeat (60) @(negedge clk);
    #2 chk("rstjob_err_set", err, 1);
    chk("rstjob_busy", busy, 1);
    #1 rst = 1'b0;
    #1 chk_reset_vals("midrst");
    err_beat = -1;
    @(negedge clk); #2;
    arv_seen = 0; ov_seen = 0;
    rst = 1'b1;
    t = 0;
    while ((r_q.size() > 0 || t < 30) && t < 1000) begin @(negedge clk); t++; end
    #2;
    chk("late_r_drained", r_q.size(), 0);
    chk("late_arvalid_seen", arv_seen, 0);
    chk("late_out_valid_seen", ov_seen, 0);
    chk("late_err", err, 0);
    chk("late_busy", busy, 0);

    run_vec("recover", vt[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axi_burst_reader.md
# axi_burst_reader

AXI4 read master that streams a contiguous array of 32-bit words from memory, e.g. vertex ranks or edge lists, into the PageRank datapath. It issues length-limited AR bursts of 64-byte lines and buffers returning R beats in a line FIFO. It then unpacks each 512-bit line into a valid/ready stream of 32-bit words, lowest address first. It connects directly to the master side of the memory slave (`axi_emu` in simulation, the shell DDR port in hardware).

## Interface
- `ID`, 0: value driven on `arid_m`; R beats with other IDs are ignored for data purposes.
- `MAX_BURST`, 16: maximum beats per AR burst (1..16).
- `FIFO_DEPTH`, 16: line FIFO entries; must be ≥ MAX_BURST, power of two.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request, sampled only in IDLE.
- `base_addr`  in  64  job start byte address; bits [5:0] ignored (line aligned).
- `count`  in  32  job length in 32-bit words.
- `busy`  out  1  high from accepted `start` through `done`.
- `done`  out  1  one-cycle pulse at job end.
- `err`  out  1  sticky for the job: any rresp ≠ 0; cleared on next accepted `start`.
- `arid_m` 16, `araddr_m` 64, `arlen_m` 8, `arsize_m` 3, `arvalid_m` 1: out; `arready_m` 1: in.
- `rid_m` 16, `rdata_m` 512, `rresp_m` 2, `rlast_m` 1, `rvalid_m` 1: in; `rready_m` 1: out.
- `out_data`  out  32  stream word.
- `out_valid`  out  1  word valid.
- `out_ready`  in  1  consumer accept.
- `out_last`  out  1  qualifies the final word of the job.

## Operation
- States: IDLE → ISSUE → DRAIN → IDLE.
- IDLE: on `start`, latch `base_addr`, lines = ceil(count/16), tail = count mod 16 (0 means 16), clear `err`, set `busy`. If count = 0, pulse `done` next cycle and return to IDLE with no AR.
- ISSUE: burst beats = min(MAX_BURST, lines remaining, 64 − addr[11:6]), so no burst crosses 4 KB. Assert AR only when free FIFO credits ≥ beats. arsize = 3'd6; arlen = beats − 1. Hold araddr/arlen stable while arvalid is high and arready is low. On handshake: reserve credits, advance addr by 64·beats, decrement lines remaining. Go to DRAIN when none remain.
- R: `rready_m` is constantly high while busy; credits guarantee space. Each beat pushes rdata into the FIFO. Nonzero rresp sets `err`; the data is still pushed.
- Unpack: word pointer 0..15 over the FIFO head, word i = rdata[32i+31:32i]. Pop the line and release one credit on the last word accepted. The last line of the job ends at word tail−1.
- `out_last` = last word of the last line. DRAIN ends when that word is accepted. `done` pulses the following cycle, and `busy` drops with it.
- `start` while busy is ignored.
- Reset mid-job: all state cleared immediately. No further AR is issued. Late R beats after reset are accepted and dropped (`rready_m` = 1 in IDLE).

## Timing
- Reset values: arvalid_m, rready_m=1, out_valid, out_last, busy, done, err = 0; arid_m = ID, arsize_m = 6; araddr/arlen = 0.
- `start` → first arvalid: 1 cycle.
- R beat accepted in cycle N → its word 0 is on `out_valid` in N+1 (when the FIFO was empty).
- Sustained throughput is 1 word/clock. Memory needs only 1 beat per 16 clocks, so AR issue overlaps draining.
- At most FIFO_DEPTH/… lines outstanding, bounded by credits. Credit release and reservation in the same cycle net correctly.
- Simultaneous FIFO push and pop of the head line is legal.

## Structure
- `axi_pkg`: AXI_ADDR_W=64, AXI_DATA_W=512, AXI_ID_W=16, AXI_SIZE_64B=3'd6, RESP_OKAY/RESP_SLVERR, WORDS_PER_LINE=16.
- Sub-module `line_fifo`: synchronous FIFO of FIFO_DEPTH × 512 bits with push/pop/count and async active-low reset. Credits are computed in the parent.

## Test plan
- base 0x1000, count 16, `out_ready`=1 → one AR (arlen 0, araddr 0x1000). Then 16 words in order, `out_last` on word 15, `done` one cycle later.
- base 0x0, count 300 → AR lens 15, 2 (19 lines). The final line yields 12 words, with `out_last` on word index 299.
- base 0xFC0, count 64 → first burst arlen 0 at 0xFC0 (4 KB boundary), then arlen 2 at 0x1000.
- count 0 → no arvalid, `done` pulse one cycle after `start`, `busy` back to 0.
- `out_ready` toggled randomly on a 2000-word job → no word lost or duplicated, FIFO never overflows, AR is stalled while credits are short.
- Slave returns SLVERR on one beat → `err`=1 through `done`, data still streamed. Then async reset mid-job → all outputs return to reset values immediately.
